// File: rtl/cpu_pkg.sv
// Shared types and default widths for the memory port arbiter.
package cpu_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_IF = 2'd1,
        ISSUE_DM = 2'd2,
        RESP     = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage : cpu_pkg

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF)
// and the data memory stage (DM). One access in flight at a time; data has
// priority. A fetch whose request drops mid-access still completes on the
// memory side, but its data is discarded and no if_ack is produced.
//
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive
// data grants made while fetch waits, the next contended grant goes to fetch.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst,
    // fetch side
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    // data side
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic                dm_ack,
    output logic [DATA_W-1:0]   dm_rdata,
    // memory port
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    // pipeline control
    output logic                stall_if,
    output logic                stall_mem,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_e          state_q,     state_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic                if_ack_q,    if_ack_d;
    logic                dm_ack_q,    dm_ack_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
    logic                cancel_q,    cancel_d;
    logic                busy_q,      busy_d;

    logic                grant_if;
    logic                grant_dm;
    owner_e              owner;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;

    // Arbitration with starvation guard; counter tracks data grants made
    // while fetch is waiting.
    always_comb begin
        grant_if     = 1'b0;
        grant_dm     = 1'b0;
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE) begin
            if (!if_req) begin
                starve_cnt_d = '0;
            end
            if (dm_req && !(if_req && starve_cnt_q >= CNT_MAX)) begin
                grant_dm = 1'b1;
                if (if_req && starve_cnt_q < CNT_MAX) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end else if (if_req) begin
                grant_if     = 1'b1;
                starve_cnt_d = '0;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Strict data priority.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state_q == IDLE) begin
            if (dm_req) begin
                grant_dm = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end
`endif

    // Next-state and registered-output logic for the access FSM.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        cancel_d    = cancel_q;
        owner       = (state_q == ISSUE_DM) ? OWN_DM : OWN_IF;

        case (state_q)
            IDLE: begin
                cancel_d = 1'b0;
                if (grant_dm) begin
                    state_d     = ISSUE_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_wstrb_d = dm_wstrb;
                end else if (grant_if) begin
                    state_d     = ISSUE_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wstrb_d = '0;
                end
            end
            ISSUE_IF, ISSUE_DM: begin
                // A fetch that drops its request is a branch flush: the
                // memory access runs to completion but the result is dropped.
                if (state_q == ISSUE_IF && !if_req) begin
                    cancel_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (owner == OWN_DM) begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = mem_rdata;
                    end else if (!cancel_q && if_req) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                // Requester drops req after its ack; no grant here so it is
                // never served twice.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            cancel_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            cancel_q    <= cancel_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_ack    = dm_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = busy_q;

    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = dm_req & ~dm_ack_q;

endmodule : mem_port_arbiter
